// File: rtl/sram_port_arbiter_if.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter_if : requester-side bundle of the SRAM port arbiter
// Rev 1.0
// ============================================================================
interface sram_port_arbiter_if #(
    parameter int NUM_PORTS = 2,
    parameter int ADDR_W    = 20,
    parameter int DATA_W    = 16
);
    localparam int GRANT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;

    logic [NUM_PORTS-1:0]        req;
    logic [NUM_PORTS-1:0]        we;
    logic [NUM_PORTS*ADDR_W-1:0] addr;
    logic [NUM_PORTS*DATA_W-1:0] wdata;
    logic [NUM_PORTS*2-1:0]      be;
    logic [NUM_PORTS-1:0]        ack;
    logic [DATA_W-1:0]           rdata;
    logic [GRANT_W-1:0]          grant_id;
    logic                        busy;

    modport master (
        output req, we, addr, wdata, be,
        input  ack, rdata, grant_id, busy
    );

    modport slave (
        input  req, we, addr, wdata, be,
        output ack, rdata, grant_id, busy
    );
endinterface
`default_nettype wire

// File: rtl/sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// sram_port_arbiter : round-robin multi-requester controller for an async SRAM
// Rev 1.0
// ============================================================================
module sram_port_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ADDR_W      = 20,
    parameter int DATA_W      = 16,
    parameter int WAIT_CYCLES = 2
) (
    input  wire logic              clk,
    input  wire logic              clear,
    sram_port_arbiter_if.slave     host,
    inout  wire logic [DATA_W-1:0] bus,
    output logic [ADDR_W-1:0]      sram_address,
    output logic                   chip_en,
    output logic                   output_enable,
    output logic                   data_enable,
    output logic                   UB,
    output logic                   LB
);
    localparam int GW    = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_DONE   = 2'd2
    } state_t;

    state_t               r_state;
    logic [GW-1:0]        r_grant;
    logic [GW-1:0]        r_last;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_we;
    logic [DATA_W-1:0]    r_wdata;
    logic [ADDR_W-1:0]    r_sram_addr;
    logic [NUM_PORTS-1:0] r_ack;
    logic [DATA_W-1:0]    r_rdata;
    logic                 r_busy;
    logic                 r_drive;
    logic                 r_ce_n;
    logic                 r_oe_n;
    logic                 r_we_n;
    logic                 r_ub_n;
    logic                 r_lb_n;

    logic [GW-1:0]        w_winner;
    logic                 w_any;
    int                   w_dist;
    int                   w_best;
    logic                 w_sel_we;
    logic [ADDR_W-1:0]    w_sel_addr;
    logic [DATA_W-1:0]    w_sel_wdata;
    logic [1:0]           w_sel_be;

    // Winner is the requesting port at the smallest circular distance past the last winner.
    always_comb begin
        w_winner = '0;
        w_any    = 1'b0;
        w_dist   = 0;
        w_best   = NUM_PORTS;
        for (int j = 0; j < NUM_PORTS; j++) begin
            w_dist = (j + NUM_PORTS - 1 - int'(r_last)) % NUM_PORTS;
            if (host.req[j] && (w_dist < w_best)) begin
                w_best   = w_dist;
                w_winner = GW'(j);
                w_any    = 1'b1;
            end
        end
    end

    always_comb begin
        w_sel_we    = 1'b0;
        w_sel_addr  = '0;
        w_sel_wdata = '0;
        w_sel_be    = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (GW'(j) == w_winner) begin
                w_sel_we    = host.we[j];
                w_sel_addr  = host.addr[j*ADDR_W +: ADDR_W];
                w_sel_wdata = host.wdata[j*DATA_W +: DATA_W];
                w_sel_be    = host.be[j*2 +: 2];
            end
        end
    end

    always_ff @(posedge clk or posedge clear) begin
        if (clear) begin
            r_state     <= S_IDLE;
            r_grant     <= '0;
            r_last      <= GW'(NUM_PORTS - 1);
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_wdata     <= '0;
            r_sram_addr <= '0;
            r_ack       <= '0;
            r_rdata     <= '0;
            r_busy      <= 1'b0;
            r_drive     <= 1'b0;
            r_ce_n      <= 1'b1;
            r_oe_n      <= 1'b1;
            r_we_n      <= 1'b1;
            r_ub_n      <= 1'b1;
            r_lb_n      <= 1'b1;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_state     <= S_ACCESS;
                        r_grant     <= w_winner;
                        r_we        <= w_sel_we;
                        r_wdata     <= w_sel_wdata;
                        r_sram_addr <= w_sel_addr;
                        r_cnt       <= CNT_W'(WAIT_CYCLES - 1);
                        r_busy      <= 1'b1;
                        r_drive     <= w_sel_we;
                        r_ce_n      <= 1'b0;
                        r_oe_n      <= w_sel_we;
                        r_we_n      <= ~w_sel_we;
                        r_ub_n      <= ~w_sel_be[1];
                        r_lb_n      <= ~w_sel_be[0];
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        if (!r_we) begin
                            r_rdata <= bus;
                        end
                        r_state <= S_DONE;
                        r_ack   <= NUM_PORTS'(1) << r_grant;
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_we_n  <= 1'b1;
                        r_ub_n  <= 1'b1;
                        r_lb_n  <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 1'b1;
                    end
                end
                S_DONE: begin
                    // Write data stays on the bus through this cycle for SRAM hold time.
                    r_state <= S_IDLE;
                    r_ack   <= '0;
                    r_last  <= r_grant;
                    r_drive <= 1'b0;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign bus           = r_drive ? r_wdata : {DATA_W{1'bz}};
    assign sram_address  = r_sram_addr;
    assign chip_en       = r_ce_n;
    assign output_enable = r_oe_n;
    assign data_enable   = r_we_n;
    assign UB            = r_ub_n;
    assign LB            = r_lb_n;

    assign host.ack      = r_ack;
    assign host.rdata    = r_rdata;
    assign host.grant_id = r_grant;
    assign host.busy     = r_busy;
endmodule
`default_nettype wire

// File: tb/tb_sram_port_arbiter.sv
`default_nettype none
// ============================================================================
// tb_sram_port_arbiter : randomized bench with transaction-level reference model
// Rev 1.0
// ============================================================================
module tb_sram_port_arbiter;
    localparam int NP  = 2;
    localparam int AW  = 20;
    localparam int DW  = 16;
    localparam int WC  = 2;
    localparam int NPB = 4;
    localparam int WCB = 1;

    logic clk = 1'b0;
    logic clear = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    sram_port_arbiter_if #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW)) ifa ();
    sram_port_arbiter_if #(.NUM_PORTS(NPB), .ADDR_W(AW), .DATA_W(DW)) ifb ();

    wire [DW-1:0] bus_a;
    wire [DW-1:0] bus_b;
    logic [AW-1:0] addr_a, addr_b;
    logic ce_a, oe_a, we_a, ub_a, lb_a;
    logic ce_b, oe_b, we_b, ub_b, lb_b;

    sram_port_arbiter #(.NUM_PORTS(NP), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WC)) dut_a (
        .clk(clk), .clear(clear), .host(ifa.slave), .bus(bus_a), .sram_address(addr_a),
        .chip_en(ce_a), .output_enable(oe_a), .data_enable(we_a), .UB(ub_a), .LB(lb_a)
    );

    sram_port_arbiter #(.NUM_PORTS(NPB), .ADDR_W(AW), .DATA_W(DW), .WAIT_CYCLES(WCB)) dut_b (
        .clk(clk), .clear(clear), .host(ifb.slave), .bus(bus_b), .sram_address(addr_b),
        .chip_en(ce_b), .output_enable(oe_b), .data_enable(we_b), .UB(ub_b), .LB(lb_b)
    );

    // Pin-level SRAM behind dut_a; only the low 8 address bits are decoded.
    logic [DW-1:0] sram_mem [0:255];
    assign bus_a = (!ce_a && !oe_a) ? sram_mem[addr_a[7:0]] : {DW{1'bz}};

    // Transaction-level reference model state
    logic [DW-1:0] ref_mem [0:255];
    int            m_phase;
    int            m_port;
    int            m_last;
    int            m_grant;
    logic          m_we;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata;
    logic [1:0]    m_be;
    logic [DW-1:0] m_rd;
    logic [DW-1:0] m_rdata;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_last  = NP - 1;
        m_grant = 0;
        m_port  = 0;
        m_we    = 1'b0;
        m_addr  = '0;
        m_wdata = '0;
        m_be    = '0;
        m_rd    = '0;
        m_rdata = '0;
    endtask

    // Access = grant edge, WC strobe cycles, one ack cycle, then free again.
    task automatic model_step();
        int k;
        if (clear) begin
            model_reset();
            return;
        end
        if (m_phase == 0) begin
            for (int off = 1; off <= NP; off++) begin
                k = (m_last + off) % NP;
                if (ifa.req[k]) begin
                    m_port  = k;
                    m_grant = k;
                    m_we    = ifa.we[k];
                    m_addr  = ifa.addr[k*AW +: AW];
                    m_wdata = ifa.wdata[k*DW +: DW];
                    m_be    = ifa.be[k*2 +: 2];
                    if (m_we) begin
                        if (m_be[1]) ref_mem[m_addr[7:0]][15:8] = m_wdata[15:8];
                        if (m_be[0]) ref_mem[m_addr[7:0]][7:0]  = m_wdata[7:0];
                    end else begin
                        m_rd = ref_mem[m_addr[7:0]];
                    end
                    m_phase = 1;
                    break;
                end
            end
        end else if (m_phase <= WC) begin
            m_phase++;
            if (m_phase == WC + 1 && !m_we) m_rdata = m_rd;
        end else begin
            m_last  = m_port;
            m_phase = 0;
        end
    endtask

    task automatic compare_a();
        logic          act;
        logic [NP-1:0] e_ack;
        act   = (m_phase >= 1) && (m_phase <= WC);
        e_ack = '0;
        if (m_phase == WC + 1) e_ack[m_port] = 1'b1;
        check("chip_en",       32'(ce_a), 32'(!act));
        check("output_enable", 32'(oe_a), 32'(!(act && !m_we)));
        check("data_enable",   32'(we_a), 32'(!(act && m_we)));
        check("UB",            32'(ub_a), 32'(act ? !m_be[1] : 1'b1));
        check("LB",            32'(lb_a), 32'(act ? !m_be[0] : 1'b1));
        check("ack",           32'(ifa.ack), 32'(e_ack));
        check("busy",          32'(ifa.busy), 32'(m_phase != 0));
        check("grant_id",      32'(ifa.grant_id), 32'(m_grant));
        check("sram_address",  32'(addr_a), 32'(m_addr));
        check("rdata",         32'(ifa.rdata), 32'(m_rdata));
        if (m_phase != 0 && m_we) check("bus_wdata", 32'(bus_a), 32'(m_wdata));
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            sram_mem[i] = 16'(i * 257) ^ 16'hA5C3;
            ref_mem[i]  = 16'(i * 257) ^ 16'hA5C3;
        end
        model_reset();
        forever begin
            @(posedge clk);
            model_step();
            @(negedge clk);
            if (!ce_a && !we_a) begin
                if (!ub_a) sram_mem[addr_a[7:0]][15:8] = bus_a[15:8];
                if (!lb_a) sram_mem[addr_a[7:0]][7:0]  = bus_a[7:0];
            end
            compare_a();
        end
    end

    task automatic access_a(input int p, input logic w, input logic [AW-1:0] a,
                            input logic [DW-1:0] d, input logic [1:0] b,
                            output int lat, output logic [DW-1:0] rd,
                            output int wcnt, output int ocnt, output logic [1:0] ublb);
        int t0;
        @(negedge clk);
        ifa.req[p] = 1'b1;
        ifa.we[p]  = w;
        ifa.addr[p*AW +: AW]  = a;
        ifa.wdata[p*DW +: DW] = d;
        ifa.be[p*2 +: 2]      = b;
        t0 = cyc; lat = -1; rd = '0; wcnt = 0; ocnt = 0; ublb = 2'b11;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (!we_a) wcnt++;
            if (!oe_a) ocnt++;
            if (!ce_a) ublb = {ub_a, lb_a};
            if (ifa.ack[p]) begin
                lat = cyc - t0;
                rd  = ifa.rdata;
                break;
            end
        end
        ifa.req[p] = 1'b0;
    endtask

    int            lat, wcnt, ocnt, acks, t0;
    logic [DW-1:0] rd;
    logic [1:0]    ublb;
    int            got[$];
    int            tms[$];
    int            waitc[NP];
    logic          pend[NP];
    int            exp_a[4] = '{0, 1, 0, 1};
    int            exp_b[4] = '{1, 3, 1, 3};

    initial begin
        ifa.req = '0; ifa.we = '0; ifa.addr = '0; ifa.wdata = '0; ifa.be = '0;
        ifb.req = '0; ifb.we = '0; ifb.addr = '0; ifb.wdata = '0; ifb.be = '0;
        repeat (3) @(negedge clk);
        check("rst_ce",    32'(ce_a), 32'd1);
        check("rst_oe",    32'(oe_a), 32'd1);
        check("rst_we",    32'(we_a), 32'd1);
        check("rst_ub_lb", 32'({ub_a, lb_a}), 32'd3);
        check("rst_ack",   32'(ifa.ack), 32'd0);
        check("rst_rdata", 32'(ifa.rdata), 32'd0);
        check("rst_busy",  32'(ifa.busy), 32'd0);
        clear = 1'b0;

        access_a(0, 1'b1, 20'h00012, 16'hBEEF, 2'b11, lat, rd, wcnt, ocnt, ublb);
        check("wr_latency", 32'(lat), 32'd3);
        check("wr_we_cycles", 32'(wcnt), 32'd2);
        access_a(0, 1'b0, 20'h00012, 16'h0000, 2'b11, lat, rd, wcnt, ocnt, ublb);
        check("rd_latency", 32'(lat), 32'd3);
        check("rd_oe_cycles", 32'(ocnt), 32'd2);
        check("rd_data", 32'(rd), 32'hBEEF);
        check("model_rd_data", 32'(m_rdata), 32'hBEEF);

        access_a(1, 1'b1, 20'h00020, 16'hFFFF, 2'b11, lat, rd, wcnt, ocnt, ublb);
        access_a(1, 1'b1, 20'h00020, 16'h1234, 2'b10, lat, rd, wcnt, ocnt, ublb);
        check("lane_ub_lb", 32'(ublb), 32'h1);
        access_a(1, 1'b0, 20'h00020, 16'h0000, 2'b11, lat, rd, wcnt, ocnt, ublb);
        check("lane_rd_data", 32'(rd), 32'h12FF);
        check("model_lane_data", 32'(m_rdata), 32'h12FF);

        // Both ports held; last winner was port 1 so port 0 goes first.
        @(negedge clk);
        ifa.we = 2'b11; ifa.be = 4'hF;
        ifa.addr = {20'h00041, 20'h00040};
        ifa.wdata = {16'h2222, 16'h1111};
        ifa.req = 2'b11;
        for (int i = 0; i < 60 && got.size() < 4; i++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (ifa.ack[p]) begin
                    got.push_back(p);
                    tms.push_back(cyc);
                end
            end
        end
        ifa.req = '0;
        check("rr_ack_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            check("rr_order", 32'(got[i]), 32'(exp_a[i]));
            if (i > 0) check("rr_spacing", 32'(tms[i] - tms[i-1]), 32'd4);
        end

        for (int p = 0; p < NP; p++) begin
            pend[p] = 1'b0;
            waitc[p] = 0;
        end
        @(negedge clk);
        for (int c = 0; c < 800; c++) begin
            @(negedge clk);
            for (int p = 0; p < NP; p++) begin
                if (pend[p] && ifa.ack[p]) begin
                    check("starvation_bound", 32'(waitc[p] <= 3 * (WC + 2) * NP), 32'd1);
                    pend[p] = 1'b0;
                    ifa.req[p] = 1'b0;
                end else if (pend[p]) begin
                    waitc[p]++;
                    if (waitc[p] > 60) begin
                        check("ack_timeout", 32'(waitc[p]), 32'd0);
                        pend[p] = 1'b0;
                        ifa.req[p] = 1'b0;
                    end else if ($urandom_range(0, 5) == 0) begin
                        ifa.we[p] = 1'($urandom);
                        ifa.addr[p*AW +: AW]  = {12'h000, 8'($urandom)};
                        ifa.wdata[p*DW +: DW] = 16'($urandom);
                        ifa.be[p*2 +: 2]      = 2'($urandom);
                    end else if (ifa.busy && int'(ifa.grant_id) == p && $urandom_range(0, 9) == 0) begin
                        ifa.req[p] = 1'b0;
                    end
                end else if ($urandom_range(0, 2) == 0) begin
                    ifa.req[p] = 1'b1;
                    ifa.we[p]  = 1'($urandom);
                    ifa.addr[p*AW +: AW]  = {12'h000, 8'($urandom)};
                    ifa.wdata[p*DW +: DW] = 16'($urandom);
                    ifa.be[p*2 +: 2]      = 2'($urandom);
                    pend[p] = 1'b1;
                    waitc[p] = 0;
                end
            end
        end
        ifa.req = '0;
        for (int i = 0; i < 20 && ifa.busy; i++) @(negedge clk);
        check("drain_idle", 32'(ifa.busy), 32'd0);
        @(negedge clk);

        // Abort a write in its second strobe cycle.
        @(negedge clk);
        ifa.we[0] = 1'b1; ifa.be[1:0] = 2'b11;
        ifa.addr[AW-1:0] = 20'h00030; ifa.wdata[DW-1:0] = 16'hCAFE;
        ifa.req[0] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        check("abort_pre_we", 32'(we_a), 32'd0);
        #1 clear = 1'b1;
        #1;
        check("abort_we_released", 32'(we_a), 32'd1);
        check("abort_ce_released", 32'(ce_a), 32'd1);
        check("abort_busy", 32'(ifa.busy), 32'd0);
        ifa.req[0] = 1'b0;
        @(negedge clk);
        #1 clear = 1'b0;
        acks = 0;
        repeat (6) begin
            @(negedge clk);
            if (ifa.ack != '0) acks++;
        end
        check("abort_no_ack", 32'(acks), 32'd0);
        access_a(1, 1'b0, 20'h00030, 16'h0000, 2'b11, lat, rd, wcnt, ocnt, ublb);
        check("post_abort_latency", 32'(lat), 32'd3);

        // Four-port instance, single wait state, ports 1 and 3 requesting.
        got.delete();
        tms.delete();
        @(negedge clk);
        ifb.we = 4'b1010; ifb.be = 8'hFF;
        ifb.addr = {20'h00003, 20'h0, 20'h00001, 20'h0};
        ifb.wdata = {16'h3333, 16'h0, 16'h1111, 16'h0};
        ifb.req = 4'b1010;
        for (int i = 0; i < 40 && got.size() < 4; i++) begin
            @(negedge clk);
            for (int p = 0; p < NPB; p++) begin
                if (ifb.ack[p]) begin
                    got.push_back(p);
                    tms.push_back(cyc);
                    check("b_grant_id", 32'(ifb.grant_id), 32'(p));
                    check("b_bus_hold", 32'(bus_b), (p == 1) ? 32'h1111 : 32'h3333);
                end
            end
        end
        ifb.req = '0;
        check("b_ack_count", 32'(got.size()), 32'd4);
        for (int i = 0; i < got.size() && i < 4; i++) begin
            check("b_order", 32'(got[i]), 32'(exp_b[i]));
            if (i > 0) check("b_spacing", 32'(tms[i] - tms[i-1]), 32'd3);
        end

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
